uart_rx_gen2: RTL and testbench

UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_rx_gen2.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx_gen2.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selectors and
// the divider helper used to turn clock/baud/oversample into a tick period.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clamped to 1 so a degenerate parameter set still yields a tick every clock.
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    int div;
    div = clk_freq / (baud_rate * oversample);
    return (div < 1) ? 1 : div;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with a register-based head so the current word is
// visible combinationally; push while full succeeds only alongside a pop.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_en;
  logic             push_en;

  assign o_valid = (count_q != '0);
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign pop_en  = i_pop && o_valid;
  assign push_en = i_push && (!o_full || pop_en);
  assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count = count_q;

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/uart_rx_gen2.sv
// Oversampling UART receiver with majority-vote bit decisions, optional parity,
// 1/2 stop bits, error pulses, idle-timeout indication and an output FIFO.
module uart_rx_gen2
  import uart_pkg::*;
#(
  parameter int CLK_FREQ         = 100000000,
  parameter int BAUD_RATE        = 115200,
  parameter int OVERSAMPLE       = 16,
  parameter int DATA_BITS        = 8,
  parameter int PARITY_MODE      = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 16,
  parameter int IDLE_TIMEOUT_CLK = 30000
) (
  input  logic                          i_clk_uart,
  input  logic                          i_rst,
  input  logic                          i_rx,
  output logic [DATA_BITS-1:0]          o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_frame_err,
  output logic                          o_parity_err,
  output logic                          o_overrun,
  output logic                          o_idle_timeout
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT_CLK + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]   S0        = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]   S1        = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]   S2        = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]   S_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT_CLK);

  rx_state_e            state_q;
  logic                 rx_meta_q;
  logic                 rx_sync_q;
  logic [DIV_W-1:0]     div_q;
  logic [OS_W-1:0]      tick_idx_q;
  logic [1:0]           samp_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_err_q;
  logic                 stop_idx_q;
  logic                 stop_bad_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_q;
  logic [IDLE_W-1:0]    idle_cnt_q;
  logic [IDLE_W-1:0]    idle_cnt_d;
  logic                 timeout_q;
  logic                 timeout_d;
  logic                 pushed_q;
  logic                 pushed_d;

  logic tick;
  logic maj;
  logic mid_done;
  logic bit_end;
  logic start_det;
  logic exp_par;
  logic decide;
  logic frame_bad;
  logic accept;
  logic push;
  logic overrun_now;
  logic fifo_full;
  logic fifo_valid;
  logic pop_fire;

  assign tick      = (div_q == DIV_LAST);
  assign maj       = majority3(samp_q[0], samp_q[1], rx_sync_q);
  assign mid_done  = tick && (tick_idx_q == S2);
  assign bit_end   = tick && (tick_idx_q == S_LAST);
  assign start_det = (state_q == ST_IDLE) && !rx_sync_q;
  assign exp_par   = (PARITY_MODE == PARITY_ODD) ? ~(^shreg_q) : (^shreg_q);

  // The frame outcome is resolved at the third vote of the final stop bit.
  assign decide      = (state_q == ST_STOP) && mid_done && (stop_idx_q == STOP_LAST);
  assign frame_bad   = stop_bad_q | ~maj;
  assign accept      = decide && !frame_bad && !par_err_q;
  assign pop_fire    = fifo_valid && i_ready;
  assign push        = accept && (!fifo_full || pop_fire);
  assign overrun_now = fifo_full && !pop_fire;

  always_ff @(posedge i_clk_uart) begin
    if (i_rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= ST_IDLE;
      div_q        <= '0;
      tick_idx_q   <= '0;
      samp_q       <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      par_err_q    <= 1'b0;
      stop_idx_q   <= 1'b0;
      stop_bad_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= i_rx;
      rx_sync_q    <= rx_meta_q;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      div_q        <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        tick_idx_q <= (tick_idx_q == S_LAST) ? '0 : tick_idx_q + 1'b1;
        if (tick_idx_q == S0) samp_q[0] <= rx_sync_q;
        if (tick_idx_q == S1) samp_q[1] <= rx_sync_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (!rx_sync_q) begin
            state_q    <= ST_START;
            div_q      <= '0;
            tick_idx_q <= '0;
            bit_idx_q  <= '0;
            par_err_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            stop_bad_q <= 1'b0;
          end
        end
        ST_START: begin
          if (mid_done && maj) state_q <= ST_IDLE;
          else if (bit_end)    state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (mid_done) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx_q == BIT_LAST)
              state_q <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            else
              bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (mid_done) par_err_q <= (maj != exp_par);
          if (bit_end)  state_q   <= ST_STOP;
        end
        ST_STOP: begin
          if (decide) begin
            if (frame_bad) begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_HIGH;
            end else begin
              parity_err_q <= par_err_q;
              overrun_q    <= !par_err_q && overrun_now;
              state_q      <= ST_IDLE;
            end
          end else begin
            if (mid_done) stop_bad_q <= stop_bad_q | ~maj;
            if (bit_end)  stop_idx_q <= stop_idx_q + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_sync_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Idle counter saturates so the timeout level stays asserted on a quiet line.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q == ST_IDLE) && rx_sync_q) begin
      if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_d = '0;
    end
    timeout_d = timeout_q;
    if (start_det)
      timeout_d = 1'b0;
    else if ((idle_cnt_q == IDLE_MAX) && pushed_q)
      timeout_d = 1'b1;
    pushed_d = pushed_q | push;
  end

  always_ff @(posedge i_clk_uart) begin
    if (i_rst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
      pushed_q   <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
      pushed_q   <= pushed_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk_uart),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (shreg_q),
    .i_pop   (i_ready),
    .o_data  (o_data),
    .o_valid (fifo_valid),
    .o_full  (fifo_full),
    .o_count (o_fifo_count)
  );

  assign o_valid        = fifo_valid;
  assign o_frame_err    = frame_err_q;
  assign o_parity_err   = parity_err_q;
  assign o_overrun      = overrun_q;
  assign o_idle_timeout = timeout_q;

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Randomized bench for uart_rx_gen2: frames are built bit by bit and the
// expected FIFO contents and error counts come from a queue-based model.
module tb_uart_rx_gen2;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int OS       = 16;
  localparam int BIT_CLKS = (CLK_FREQ / (BAUD * OS)) * OS;
  localparam int TMO      = 2000;
  localparam int DEPTH    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx, ready, rx_p, ready_p;
  logic [7:0] data, data_p;
  logic       valid, valid_p;
  logic [4:0] cnt, cnt_p;
  logic       fe, pe, ov, tmo, fe_p, pe_p, ov_p, tmo_p;

  uart_rx_gen2 #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
    .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT_CLK(TMO)
  ) dut (
    .i_clk_uart(clk), .i_rst(rst), .i_rx(rx), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_fifo_count(cnt), .o_frame_err(fe), .o_parity_err(pe),
    .o_overrun(ov), .o_idle_timeout(tmo)
  );

  uart_rx_gen2 #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
    .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT_CLK(TMO)
  ) dut_par (
    .i_clk_uart(clk), .i_rst(rst), .i_rx(rx_p), .o_data(data_p), .o_valid(valid_p),
    .i_ready(ready_p), .o_fifo_count(cnt_p), .o_frame_err(fe_p), .o_parity_err(pe_p),
    .o_overrun(ov_p), .o_idle_timeout(tmo_p)
  );

  int total, bad;
  int n_fe, n_pe, n_ov, p_fe, p_pe, p_ov;
  int exp_fe, exp_pe, exp_ov, exp_p_fe, exp_p_pe;
  logic [7:0] model_q[$];
  logic [7:0] model_p[$];

  always @(negedge clk) begin
    if (fe)   n_fe++;
    if (pe)   n_pe++;
    if (ov)   n_ov++;
    if (fe_p) p_fe++;
    if (pe_p) p_pe++;
    if (ov_p) p_ov++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input bit par_line);
    if (par_line) rx_p = b;
    else          rx   = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
    drive_bit(stop_b, 1'b0);
    $display("tx 0x%02h stop=%0b", d, stop_b);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_ok);
    if (!stop_ok)                     exp_fe++;
    else if (model_q.size() == DEPTH) exp_ov++;
    else                              model_q.push_back(d);
  endtask

  task automatic check_fifo(input string tag);
    check({tag, ".count"}, 32'(cnt), model_q.size());
    check({tag, ".valid"}, 32'(valid), 32'(model_q.size() != 0));
    check({tag, ".data"}, 32'(data), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
    check({tag, ".frame_err"}, n_fe, exp_fe);
    check({tag, ".parity_err"}, n_pe, exp_pe);
    check({tag, ".overrun"}, n_ov, exp_ov);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    wait_clks(1);
    ready = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic send_par(input logic [7:0] d, input logic par);
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b1);
    drive_bit(par, 1'b1);
    drive_bit(1'b1, 1'b1);
    $display("tx_par 0x%02h parity=%0b", d, par);
    if (par != (^d)) exp_p_pe++;
    else             model_p.push_back(d);
    check("par.count", 32'(cnt_p), model_p.size());
    check("par.data", 32'(data_p), (model_p.size() != 0) ? 32'(model_p[0]) : 32'd0);
    check("par.parity_err", p_pe, exp_p_pe);
    check("par.frame_err", p_fe, exp_p_fe);
    check("par.overrun", p_ov, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       s;
    rst = 1'b1; rx = 1'b1; rx_p = 1'b1; ready = 1'b0; ready_p = 1'b0;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2);
    check_fifo("reset");
    check("reset.timeout", 32'(tmo), 0);

    wait_clks(TMO + 100);
    check("no_word.timeout", 32'(tmo), 0);

    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    check_fifo("a5");
    pop_one();
    check_fifo("a5_pop");

    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 5) != 0);
      send_frame(d, s);
      model_frame(d, s);
      if (!s || $urandom_range(0, 1) == 1) drive_bit(1'b1, 1'b0);
      check_fifo("rnd");
      if (model_q.size() != 0 && $urandom_range(0, 2) == 0) pop_one();
    end
    while (model_q.size() != 0) begin
      check_fifo("drain");
      pop_one();
    end

    for (int n = 0; n < 17; n++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1);
      model_frame(d, 1'b1);
    end
    check_fifo("overrun");
    while (model_q.size() != 0) begin
      check_fifo("ovr_drain");
      pop_one();
    end

    rx = 1'b0;
    wait_clks(30 * BIT_CLKS);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    exp_fe++;
    check_fifo("break");
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    check_fifo("after_break");
    pop_one();

    rx = 1'b0;
    wait_clks(BIT_CLKS * 3 / 10);
    rx = 1'b1;
    wait_clks(11 * BIT_CLKS);
    check_fifo("glitch");
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    check_fifo("post_glitch");

    check("tmo.after_frame", 32'(tmo), 0);
    wait_clks(TMO - 200);
    check("tmo.before", 32'(tmo), 0);
    wait_clks(400);
    check("tmo.reached", 32'(tmo), 1);
    rx = 1'b0;
    wait_clks(5);
    check("tmo.start_clears", 32'(tmo), 0);
    wait_clks(BIT_CLKS - 5);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    rst = 1'b1;
    wait_clks(2);
    check("rst.count", 32'(cnt), 0);
    check("rst.valid", 32'(valid), 0);
    check("rst.data", 32'(data), 0);
    check("rst.timeout", 32'(tmo), 0);
    model_q.delete();
    rx = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    wait_clks(12 * BIT_CLKS);
    check_fifo("post_reset");

    send_par(8'h03, 1'b1);
    send_par(8'h03, 1'b0);
    for (int n = 0; n < 6; n++) begin
      send_par(8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
